mas_prog_loader: RTL

Parametrised program loader for the MAS16bA core. It replaces bench-driven instruction loading with a synthesizable streaming loader. It accepts a word stream over a valid/ready handshake, writes the words into instruction memory from a base address, and verifies an XOR checksum trailer. It holds the core in reset during loading and releases it after a programmable reset stretch. It sits between a host link (UART/SPI deframer) and the core's instruction-memory write port plus core reset.

---
 rtl/mas_prog_loader_if.sv | 30 +++
 rtl/mas_prog_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mas_prog_loader_if.sv
// Host-side stream and instruction-memory write bundle for the MAS16bA program loader.
// The host (master) drives the load request and stream; the loader (slave) drives the rest.
interface mas_prog_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W-1:0] word_cnt;

    modport master (
        output start, len, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err, word_cnt
    );

    modport slave (
        input  start, len, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err, word_cnt
    );
endinterface

// File: rtl/mas_prog_loader.sv
// Streaming program loader: writes a word stream into instruction memory from BASE,
// checks an XOR trailer, and holds the core in reset until a verified image is loaded.
module mas_prog_loader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 65536,
    parameter int BASE       = 0,
    parameter int RST_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    mas_prog_loader_if.slave    bus
);
    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   BASE_X  = BASE[ADDR_W:0];
    localparam logic [ADDR_W:0]   SPAN_X  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_A  = BASE_X[ADDR_W-1:0];

    typedef enum logic [2:0] {
        IDLE, LOAD, CHECK, RELEASE, RUN, ERR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [DATA_W-1:0] csum_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  rst_cnt_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W:0]   len_ext_d;
    logic [ADDR_W:0]   end_x_d;
    logic              len_bad_d;
    logic              xfer_d;

    // A program is rejected if it exceeds DEPTH or its last word would wrap past the address space.
    assign len_ext_d = {1'b0, bus.len};
    assign end_x_d   = BASE_X + len_ext_d;
    assign len_bad_d = (len_ext_d > DEPTH_X) || ((bus.len != '0) && (end_x_d > SPAN_X));
    assign xfer_d    = bus.in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            err_q       <= 2'b00;
            rst_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_A;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, RUN, ERR: begin
                    if (bus.start) begin
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        if (len_bad_d) begin
                            state_q    <= ERR;
                            err_q      <= 2'b10;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else begin
                            len_q      <= bus.len;
                            word_cnt_q <= '0;
                            csum_q     <= '0;
                            err_q      <= 2'b00;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= (bus.len == '0) ? CHECK : LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer_d) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_A + word_cnt_q;
                        mem_wdata_q <= bus.in_data;
                        csum_q      <= csum_q ^ bus.in_data;
                        word_cnt_q  <= word_cnt_q + ADDR_W'(1);
                        if (word_cnt_q + ADDR_W'(1) == len_q) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // The trailer is consumed here and never reaches memory.
                    if (xfer_d) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_data == csum_q) begin
                            state_q   <= RELEASE;
                            rst_cnt_q <= '0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 2'b01;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule
